// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: header target codes, header
// field positions, loader states and header record type.
package loader_pkg;

    // Header target field encodings
    typedef enum logic [1:0] {
        TGT_IMEM = 2'b00,
        TGT_DMEM = 2'b01,
        TGT_REG  = 2'b10,
        TGT_GO   = 2'b11
    } tgt_e;

    // Loader sequencing states
    typedef enum logic [1:0] {
        HDR  = 2'b00,
        DATA = 2'b01,
        RUN  = 2'b10
    } state_e;

    // Header word field positions
    localparam int HDR_TGT_MSB  = 31;
    localparam int HDR_TGT_LSB  = 30;
    localparam int HDR_BASE_MSB = 23;
    localparam int HDR_BASE_LSB = 16;
    localparam int HDR_CNT_MSB  = 8;
    localparam int HDR_CNT_LSB  = 0;

    localparam int BASE_W = HDR_BASE_MSB - HDR_BASE_LSB + 1;
    localparam int CNT_W  = HDR_CNT_MSB - HDR_CNT_LSB + 1;

    // Decoded header fields
    typedef struct packed {
        tgt_e              tgt;
        logic [BASE_W-1:0] base;
        logic [CNT_W-1:0]  count;
    } hdr_t;

    // True when a body of cnt words starting at base runs past the end of an
    // array of the given depth (the addresses will wrap).
    function automatic logic range_exceeds(input logic [BASE_W-1:0] base,
                                           input logic [CNT_W-1:0]  cnt,
                                           input int                depth);
        logic [31:0] last_excl;
        last_excl = 32'(base) + 32'(cnt);
        return last_excl > 32'(depth);
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Stream input plus the three storage write ports and CPU control/status of
// the program loader. The loader uses the slave view; the stream source and
// the storage/CPU side use the master view.
interface program_loader_if #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 32,
    parameter int DATA_W     = 32
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    // Word stream
    logic              in_valid_i;
    logic [DATA_W-1:0] in_data_i;
    logic              in_ready_o;

    // Storage write ports (shared write data)
    logic              imem_we_o;
    logic [IAW-1:0]    imem_addr_o;
    logic              dmem_we_o;
    logic [DAW-1:0]    dmem_addr_o;
    logic              reg_we_o;
    logic [4:0]        reg_addr_o;
    logic [DATA_W-1:0] wdata_o;

    // CPU control and status
    logic              cpu_rst_o;
    logic              busy_o;
    logic              err_o;

    modport slave (
        input  in_valid_i, in_data_i,
        output in_ready_o,
        output imem_we_o, imem_addr_o, dmem_we_o, dmem_addr_o,
        output reg_we_o, reg_addr_o, wdata_o,
        output cpu_rst_o, busy_o, err_o
    );

    modport master (
        output in_valid_i, in_data_i,
        input  in_ready_o,
        input  imem_we_o, imem_addr_o, dmem_we_o, dmem_addr_o,
        input  reg_we_o, reg_addr_o, wdata_o,
        input  cpu_rst_o, busy_o, err_o
    );

endinterface

// File: rtl/loader_hdr_decode.sv
// Combinational header decoder: splits a header word into target, base and
// count and flags bodies that would run past the end of their target array.
module loader_hdr_decode
    import loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 32,
    parameter int REG_COUNT  = 32
) (
    input  logic [31:0] word_i,
    output hdr_t        hdr_o,
    output logic        ovf_o
);

    // Bits outside the three fields carry no meaning in a header
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^{word_i[29:24], word_i[15:9]};

    // Field extraction and per-target overflow check
    always_comb begin
        hdr_o.tgt   = tgt_e'(word_i[HDR_TGT_MSB:HDR_TGT_LSB]);
        hdr_o.base  = word_i[HDR_BASE_MSB:HDR_BASE_LSB];
        hdr_o.count = word_i[HDR_CNT_MSB:HDR_CNT_LSB];
        ovf_o       = 1'b0;
        case (hdr_o.tgt)
            TGT_IMEM: ovf_o = range_exceeds(hdr_o.base, hdr_o.count, IMEM_DEPTH);
            TGT_DMEM: ovf_o = range_exceeds(hdr_o.base, hdr_o.count, DMEM_DEPTH);
            TGT_REG:  ovf_o = range_exceeds(hdr_o.base, hdr_o.count, REG_COUNT);
            default:  ovf_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/program_loader.sv
// Boot-time writer for the CPU's instruction memory, data memory and register
// file. Parses a framed word stream (header + body words), issues one
// registered write per body word, holds the CPU in reset until a GO header.
module program_loader
    import loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int DATA_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    program_loader_if.slave  bus
);

    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);
    localparam int RAW = 5;

    // Sequencing state
    state_e            state_q, state_d;
    tgt_e              tgt_q, tgt_d;
    logic [BASE_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic              err_q, err_d;

    // Registered write port outputs
    logic              imem_we_q, imem_we_d;
    logic              dmem_we_q, dmem_we_d;
    logic              reg_we_q, reg_we_d;
    logic [IAW-1:0]    imem_addr_q, imem_addr_d;
    logic [DAW-1:0]    dmem_addr_q, dmem_addr_d;
    logic [RAW-1:0]    reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    hdr_t              hdr;
    logic              hdr_ovf;
    logic              in_ready;
    logic              accept;
    logic              last_word;
    logic [IAW-1:0]    imem_cur_addr;
    logic [DAW-1:0]    dmem_cur_addr;
    logic [RAW-1:0]    reg_cur_addr;

    loader_hdr_decode #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .DMEM_DEPTH (DMEM_DEPTH),
        .REG_COUNT  (REG_COUNT)
    ) u_hdr_decode (
        .word_i (bus.in_data_i),
        .hdr_o  (hdr),
        .ovf_o  (hdr_ovf)
    );

    // Once the CPU is running the stream is no longer consumed
    assign in_ready  = (state_q != RUN);
    assign accept    = bus.in_valid_i && in_ready;
    assign last_word = (idx_q == cnt_q - CNT_W'(1));

    // Truncating both operands to the array's address width gives the
    // modulo-depth wrap for free (depths are powers of two).
    assign imem_cur_addr = IAW'(base_q) + IAW'(idx_q);
    assign dmem_cur_addr = DAW'(base_q) + DAW'(idx_q);
    assign reg_cur_addr  = RAW'(base_q) + RAW'(idx_q);

    // Next-state, command latching and write generation
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        err_d       = err_q;
        imem_we_d   = 1'b0;
        dmem_we_d   = 1'b0;
        reg_we_d    = 1'b0;
        imem_addr_d = imem_addr_q;
        dmem_addr_d = dmem_addr_q;
        reg_addr_d  = reg_addr_q;
        wdata_d     = wdata_q;

        case (state_q)
            HDR: begin
                if (accept) begin
                    if (hdr.tgt == TGT_GO) begin
                        state_d = RUN;
                    end else if (hdr.count != '0) begin
                        tgt_d   = hdr.tgt;
                        base_d  = hdr.base;
                        cnt_d   = hdr.count;
                        idx_d   = '0;
                        state_d = DATA;
                        if (hdr_ovf) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end

            DATA: begin
                if (accept) begin
                    wdata_d = bus.in_data_i;
                    case (tgt_q)
                        TGT_IMEM: begin
                            imem_we_d   = 1'b1;
                            imem_addr_d = imem_cur_addr;
                        end
                        TGT_DMEM: begin
                            dmem_we_d   = 1'b1;
                            dmem_addr_d = dmem_cur_addr;
                        end
                        TGT_REG: begin
                            // x0 is hardwired; the word is consumed but not written
                            reg_addr_d = reg_cur_addr;
                            reg_we_d   = (reg_cur_addr != '0);
                        end
                        default: begin
                        end
                    endcase
                    idx_d = idx_q + CNT_W'(1);
                    if (last_word) begin
                        state_d = HDR;
                    end
                end
            end

            RUN: begin
            end

            default: begin
                state_d = HDR;
            end
        endcase
    end

    // State and output registers; reset discards any partial command
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= HDR;
            tgt_q       <= TGT_IMEM;
            base_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            reg_we_q    <= 1'b0;
            imem_addr_q <= '0;
            dmem_addr_q <= '0;
            reg_addr_q  <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            imem_we_q   <= imem_we_d;
            dmem_we_q   <= dmem_we_d;
            reg_we_q    <= reg_we_d;
            imem_addr_q <= imem_addr_d;
            dmem_addr_q <= dmem_addr_d;
            reg_addr_q  <= reg_addr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.imem_we_o   = imem_we_q;
    assign bus.imem_addr_o = imem_addr_q;
    assign bus.dmem_we_o   = dmem_we_q;
    assign bus.dmem_addr_o = dmem_addr_q;
    assign bus.reg_we_o    = reg_we_q;
    assign bus.reg_addr_o  = reg_addr_q;
    assign bus.wdata_o     = wdata_q;
    // CPU reset follows the state register, so it drops on the GO edge and
    // reasserts immediately with the asynchronous loader reset.
    assign bus.cpu_rst_o   = (state_q != RUN);
    assign bus.busy_o      = (state_q == DATA);
    assign bus.err_o       = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: directed vector table, hand-written reset/GO
// sequences and a randomized stream checked against a queue-based model.
module tb_program_loader;

    bit   clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    program_loader_if #(.IMEM_DEPTH(256), .DMEM_DEPTH(32), .DATA_W(32)) bus ();

    program_loader #(
        .IMEM_DEPTH (256),
        .DMEM_DEPTH (32),
        .REG_COUNT  (32),
        .DATA_W     (32)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit          v;
        logic [31:0] d;
        logic [2:0]  we;     // {reg, dmem, imem}
        logic [7:0]  addr;
        logic [31:0] wd;
        bit          busy;
        bit          err;
        bit          cpu;
        bit          rdy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit v, logic [31:0] d, logic [2:0] we, logic [7:0] a,
                                logic [31:0] wd, bit busy, bit err, bit cpu, bit rdy);
        vec_t r;
        r.v = v; r.d = d; r.we = we; r.addr = a; r.wd = wd;
        r.busy = busy; r.err = err; r.cpu = cpu; r.rdy = rdy;
        return r;
    endfunction

    // Drive one word at the falling edge, let the rising edge act, return at
    // the next falling edge where outputs are stable.
    task automatic step(input bit v, input logic [31:0] d);
        bus.in_valid_i = v;
        bus.in_data_i  = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic compare(input string name, input logic [2:0] ewe, input logic [7:0] eaddr,
                           input logic [31:0] ewd, input bit ebusy, input bit eerr,
                           input bit ecpu, input bit erdy);
        logic [2:0] awe;
        logic [7:0] aaddr;
        bit         ok;
        awe = {bus.reg_we_o, bus.dmem_we_o, bus.imem_we_o};
        if (bus.imem_we_o)      aaddr = bus.imem_addr_o;
        else if (bus.dmem_we_o) aaddr = 8'(bus.dmem_addr_o);
        else                    aaddr = 8'(bus.reg_addr_o);
        ok = (awe == ewe) && (bus.busy_o == ebusy) && (bus.err_o == eerr) &&
             (bus.cpu_rst_o == ecpu) && (bus.in_ready_o == erdy);
        if (ewe != 3'b000) ok = ok && (aaddr == eaddr) && (bus.wdata_o == ewd);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got we=%b addr=%0d wdata=%h busy=%b err=%b cpu_rst=%b ready=%b; want we=%b addr=%0d wdata=%h busy=%b err=%b cpu_rst=%b ready=%b",
                     name, awe, aaddr, bus.wdata_o, bus.busy_o, bus.err_o, bus.cpu_rst_o,
                     bus.in_ready_o, ewe, eaddr, ewd, ebusy, eerr, ecpu, erdy);
        end else begin
            $display("ok   %s: we=%b addr=%0d wdata=%h busy=%b err=%b cpu_rst=%b ready=%b",
                     name, awe, aaddr, bus.wdata_o, bus.busy_o, bus.err_o, bus.cpu_rst_o,
                     bus.in_ready_o);
        end
    endtask

    // ---------------- reference model ----------------
    // A header expands into a queue of write slots; each body word consumes
    // one slot. The CPU is released once a GO header is seen.
    typedef struct {
        int         tgt;
        logic [7:0] addr;
        bit         drop;
    } slot_t;

    slot_t       pending[$];
    bit          m_run;
    bit          m_err;
    logic [2:0]  e_we;
    logic [7:0]  e_addr;
    logic [31:0] e_wd;
    bit          e_busy, e_err, e_cpu, e_rdy;

    task automatic model_reset();
        pending.delete();
        m_run = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_word(input bit v, input logic [31:0] d);
        e_we = 3'b000; e_addr = 8'd0; e_wd = 32'd0;
        if (v && !m_run) begin
            if (pending.size() > 0) begin
                slot_t s;
                s = pending.pop_front();
                if (!s.drop) begin
                    e_we   = 3'b001 << s.tgt;
                    e_addr = s.addr;
                    e_wd   = d;
                end
            end else begin
                int t, b, c, depth;
                t = int'(d >> 30);
                b = int'((d >> 16) & 32'hFF);
                c = int'(d & 32'h1FF);
                depth = (t == 0) ? 256 : 32;
                if (t == 3) begin
                    m_run = 1'b1;
                end else if (c > 0) begin
                    if (b + c > depth) m_err = 1'b1;
                    for (int k = 0; k < c; k++) begin
                        slot_t s;
                        s.tgt  = t;
                        s.addr = 8'((b + k) % depth);
                        s.drop = (t == 2) && (((b + k) % depth) == 0);
                        pending.push_back(s);
                    end
                end
            end
        end
        e_busy = (pending.size() > 0);
        e_err  = m_err;
        e_cpu  = !m_run;
        e_rdy  = !m_run;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = 32'd0;
        repeat (2) @(negedge clk);
        compare("reset", 3'b000, 8'd0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        rst_n = 1'b1;

        // ---------- directed vector table ----------
        // IMEM base 0 count 3
        tbl.push_back(mk(1, 32'h0000_0003, 3'b000, 8'd0,  32'h0,          1, 0, 1, 1));
        tbl.push_back(mk(1, 32'h0050_0093, 3'b001, 8'd0,  32'h0050_0093,  1, 0, 1, 1));
        tbl.push_back(mk(1, 32'h00A0_0113, 3'b001, 8'd1,  32'h00A0_0113,  1, 0, 1, 1));
        tbl.push_back(mk(1, 32'h0020_81B3, 3'b001, 8'd2,  32'h0020_81B3,  0, 0, 1, 1));
        // DMEM base 30 count 4: wraps and overflows
        tbl.push_back(mk(1, 32'h401E_0004, 3'b000, 8'd0,  32'h0,          1, 1, 1, 1));
        tbl.push_back(mk(1, 32'd5,         3'b010, 8'd30, 32'd5,          1, 1, 1, 1));
        tbl.push_back(mk(1, 32'd6,         3'b010, 8'd31, 32'd6,          1, 1, 1, 1));
        tbl.push_back(mk(1, 32'd10,        3'b010, 8'd0,  32'd10,         1, 1, 1, 1));
        tbl.push_back(mk(1, 32'd18,        3'b010, 8'd1,  32'd18,         0, 1, 1, 1));
        // REG base 0 count 2: x0 dropped
        tbl.push_back(mk(1, 32'h8000_0002, 3'b000, 8'd0,  32'h0,          1, 1, 1, 1));
        tbl.push_back(mk(1, 32'd7,         3'b000, 8'd0,  32'h0,          1, 1, 1, 1));
        tbl.push_back(mk(1, 32'd9,         3'b100, 8'd1,  32'd9,          0, 1, 1, 1));
        // count 0 header: no effect
        tbl.push_back(mk(1, 32'h0010_0000, 3'b000, 8'd0,  32'h0,          0, 1, 1, 1));
        // IMEM base 16 count 2 with a 3-cycle valid gap
        tbl.push_back(mk(1, 32'h0010_0002, 3'b000, 8'd0,  32'h0,          1, 1, 1, 1));
        tbl.push_back(mk(1, 32'hAAAA_0001, 3'b001, 8'd16, 32'hAAAA_0001,  1, 1, 1, 1));
        tbl.push_back(mk(0, 32'hDEAD_BEEF, 3'b000, 8'd0,  32'h0,          1, 1, 1, 1));
        tbl.push_back(mk(0, 32'h0000_0003, 3'b000, 8'd0,  32'h0,          1, 1, 1, 1));
        tbl.push_back(mk(0, 32'hC000_0000, 3'b000, 8'd0,  32'h0,          1, 1, 1, 1));
        tbl.push_back(mk(1, 32'h5555_0002, 3'b001, 8'd17, 32'h5555_0002,  0, 1, 1, 1));
        tbl.push_back(mk(0, 32'h0000_0000, 3'b000, 8'd0,  32'h0,          0, 1, 1, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v, tbl[i].d);
            compare($sformatf("table%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wd,
                    tbl[i].busy, tbl[i].err, tbl[i].cpu, tbl[i].rdy);
        end

        // ---------- reset in the middle of a DMEM body ----------
        step(1, 32'h4002_0004);
        compare("mid_hdr", 3'b000, 8'd0, 32'd0, 1, 1, 1, 1);
        step(1, 32'h0000_0011);
        compare("mid_word0", 3'b010, 8'd2, 32'h11, 1, 1, 1, 1);
        bus.in_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 compare("mid_async_rst", 3'b000, 8'd0, 32'd0, 0, 0, 1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h0005_0001);
        compare("post_rst_hdr", 3'b000, 8'd0, 32'd0, 1, 0, 1, 1);
        step(1, 32'h0000_1234);
        compare("post_rst_word", 3'b001, 8'd5, 32'h1234, 0, 0, 1, 1);
        step(0, 32'd0);
        compare("post_rst_idle", 3'b000, 8'd0, 32'd0, 0, 0, 1, 1);

        // ---------- randomized stream against the model ----------
        model_reset();
        for (int i = 0; i < 400; i++) begin
            bit          v;
            logic [31:0] d;
            v = ($urandom_range(0, 3) != 0);
            if (pending.size() == 0) begin
                int t, b, c;
                t = $urandom_range(0, 2);
                if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 255);
                else if (t == 0)                b = $urandom_range(0, 250);
                else                            b = $urandom_range(0, 28);
                c = $urandom_range(0, 5);
                d = (32'(t) << 30) | (32'(b) << 16) | 32'(c) | ($urandom & 32'h3F00_FE00);
            end else begin
                d = $urandom;
            end
            model_word(v, d);
            step(v, d);
            compare("rand", e_we, e_addr, e_wd, e_busy, e_err, e_cpu, e_rdy);
        end

        // drain any open body so GO lands on a header
        for (int i = 0; i < 10 && pending.size() > 0; i++) begin
            logic [31:0] d;
            d = $urandom;
            model_word(1, d);
            step(1, d);
            compare("drain", e_we, e_addr, e_wd, e_busy, e_err, e_cpu, e_rdy);
        end

        // ---------- GO, ignored stream, reset out of RUN ----------
        begin
            logic [31:0] d;
            d = 32'hC000_0000 | ($urandom & 32'h3F00_FE00);
            model_word(1, d);
            step(1, d);
            compare("go_accept", e_we, e_addr, e_wd, e_busy, e_err, 0, 0);
        end
        for (int i = 0; i < 6; i++) begin
            logic [31:0] d;
            d = (i % 2 == 0) ? 32'h0000_0002 : $urandom;
            model_word(1, d);
            step(1, d);
            compare("run_ignore", e_we, e_addr, e_wd, e_busy, e_err, e_cpu, e_rdy);
        end
        bus.in_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1 compare("run_async_rst", 3'b000, 8'd0, 32'd0, 0, 0, 1, 1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 32'h801F_0002);
        compare("reg_wrap_hdr", 3'b000, 8'd0, 32'd0, 1, 1, 1, 1);
        step(1, 32'hCAFE_0001);
        compare("reg_wrap_31", 3'b100, 8'd31, 32'hCAFE_0001, 1, 1, 1, 1);
        step(1, 32'hCAFE_0002);
        compare("reg_wrap_x0", 3'b000, 8'd0, 32'd0, 0, 1, 1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
